fec_descrambler: RTL

//  Downstream of the FEC correction stage. Takes corrected 65-bit transcoded blocks (C_BLK/C_BLK_ENA).

---
 rtl/fec_descrambler.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fec_descrambler.sv
// fec_descrambler: self-synchronous descrambler (G(x)=1+x^39+x^58) for corrected
// 65-bit transcoded blocks, re-expanded to 66-bit blocks with a sync header.
// Optional illegal control-block-type counter built when FEC_DESCR_ILL_TYPE_CNT_EN
// is defined; otherwise CSR_ILL_TYPE_CNT reads 0 and CSR_CNT_CLR is ignored.
module fec_descrambler #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PRIME_BLKS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FEC_LOCK,
  input  logic             C_BLK_ENA,
  input  logic [64:0]      C_BLK,
  input  logic             CSR_CNT_CLR,
  output logic             D_BLK_ENA,
  output logic [65:0]      D_BLK,
  output logic [CNT_W-1:0] CSR_ILL_TYPE_CNT,
  output logic             CSR_DESCR_RUN
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam logic [1:0] PRIME_LAST = 2'(PRIME_BLKS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [57:0] scr_state;
  logic [1:0]  prime_cnt;
  logic [121:0] ext;
  logic [63:0] descr;
  logic        prime_load;
  logic        prime_done;
  logic        accept;
  logic        in_idle;

  // Prior 58 scrambled bits sit below the current block so every tap is a fixed offset.
  assign ext = {C_BLK[63:0], scr_state};

  // Fully unrolled descrambler: out[i] = s[i] ^ s[i-39] ^ s[i-58]
  always_comb begin
    descr = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      descr[i] = ext[i + 58] ^ ext[i + 19] ^ ext[i];
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic; loss of lock forces IDLE from any state
  always_comb begin
    state_nxt = state;
    if (!FEC_LOCK) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_PRIME;
        S_PRIME: if (prime_done) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: which blocks are consumed and whether they produce output
  always_comb begin
    in_idle    = (state == S_IDLE);
    prime_load = (state == S_PRIME) && FEC_LOCK && C_BLK_ENA;
    prime_done = prime_load && (prime_cnt == PRIME_LAST);
    accept     = (state == S_RUN) && FEC_LOCK && C_BLK_ENA;
  end

  assign CSR_DESCR_RUN = (state == S_RUN);

  // Descrambler history and prime counter; cleared while idle, advance on consumed blocks only
  always_ff @(posedge CLK) begin
    if (RST || in_idle) begin
      scr_state <= '0;
      prime_cnt <= '0;
    end else begin
      if (prime_load || accept) scr_state <= C_BLK[63:6];
      if (prime_load)           prime_cnt <= prime_cnt + 2'd1;
    end
  end

  // Output register; D_BLK holds its last value between valid blocks
  always_ff @(posedge CLK) begin
    if (RST) begin
      D_BLK_ENA <= 1'b0;
      D_BLK     <= '0;
    end else begin
      D_BLK_ENA <= accept;
      if (accept) D_BLK <= {descr, (C_BLK[64] ? 2'b01 : 2'b10)};
    end
  end

`ifdef FEC_DESCR_ILL_TYPE_CNT_EN
  logic             type_legal;
  logic             ill_inc;
  logic [CNT_W-1:0] ill_cnt;

  // Legal control block-type bytes
  always_comb begin
    type_legal = 1'b0;
    case (descr[7:0])
      8'h1E, 8'h2D, 8'h33, 8'h66, 8'h55, 8'h78, 8'h4B, 8'h87,
      8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: type_legal = 1'b1;
      default: type_legal = 1'b0;
    endcase
  end

  assign ill_inc = accept && !C_BLK[64] && !type_legal;

  // Saturating counter; a clear pulse overrides a coincident increment
  always_ff @(posedge CLK) begin
    if (RST || CSR_CNT_CLR)         ill_cnt <= '0;
    else if (ill_inc && ill_cnt != '1) ill_cnt <= ill_cnt + 1'b1;
  end

  assign CSR_ILL_TYPE_CNT = ill_cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr   = CSR_CNT_CLR;
  assign CSR_ILL_TYPE_CNT = '0;
`endif

endmodule
